// File: rtl/uart_core.sv
// rtl/uart_core.sv - byte-level 8N1 UART transceiver with valid/ready handshakes
//
// Purpose: serialises bytes onto SOut (start bit, 8 data bits LSB first, stop bit).
//          Deserialises bytes from SIn into a receive buffer.
// Optional feature macro: UART_RX_FIFO_EN
//   defined   -> 4-entry circular receive FIFO
//   undefined -> single-byte holding register
// Parameters:
//   ClockFreq  system clock frequency in Hz
//   BaudRate   line rate in bit/s; ClockFreq/BaudRate must be >= 4
// Ports:
//   Clock         system clock, rising edge
//   Reset         asynchronous active-high reset
//   DataIn        byte to transmit
//   DataInValid   transmit request
//   DataInReady   transmitter can accept a byte
//   DataOut       head received byte
//   DataOutValid  DataOut holds an unread byte
//   DataOutReady  consumer pops the head byte
//   SIn           serial receive line, asynchronous, idle high
//   SOut          serial transmit line, idle high

module uart_core #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SIn,
  output logic       SOut
);

  localparam int SymbolEdge = ClockFreq / BaudRate;
  localparam int CW         = (SymbolEdge > 1) ? $clog2(SymbolEdge) : 1;
  localparam logic [CW-1:0] SYM_LAST  = CW'(SymbolEdge - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SymbolEdge / 2 - 1);

  // ---------------------------------------------------------------- transmitter
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [9:0]    tx_shift;
  logic [3:0]    tx_bit_cnt;
  logic [CW-1:0] tx_cyc;
  logic          tx_fire;
  logic          tx_sym_end;

  assign DataInReady = (tx_state == TX_IDLE);
  assign tx_fire     = DataInValid & DataInReady;
  assign tx_sym_end  = (tx_cyc == SYM_LAST);
  // Decoded from the state register so reset forces the line idle at once.
  assign SOut        = (tx_state == TX_SHIFT) ? tx_shift[0] : 1'b1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_fire) tx_next = TX_SHIFT;
      TX_SHIFT: if (tx_sym_end && tx_bit_cnt == 4'd9) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tx_shift   <= 10'h3FF;
      tx_bit_cnt <= 4'd0;
      tx_cyc     <= '0;
    end else if (tx_fire) begin
      tx_shift   <= {1'b1, DataIn, 1'b0};
      tx_bit_cnt <= 4'd0;
      tx_cyc     <= '0;
    end else if (tx_state == TX_SHIFT) begin
      if (tx_sym_end) begin
        tx_cyc     <= '0;
        tx_shift   <= {1'b1, tx_shift[9:1]};
        tx_bit_cnt <= (tx_bit_cnt == 4'd9) ? 4'd0 : tx_bit_cnt + 4'd1;
      end else begin
        tx_cyc <= tx_cyc + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_sync1, rx_sync2, rx_prev;
  logic [CW-1:0] rx_cyc;
  logic [3:0]    rx_bit_cnt;
  logic [7:0]    rx_data;
  logic          rx_push;
  logic          rx_fall;
  logic          rx_half;
  logic          rx_sym;

  // rx_prev is a third stage used only for edge detection on the synchronised line.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= SIn;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync2;
  assign rx_half = (rx_cyc == HALF_LAST);
  assign rx_sym  = (rx_cyc == SYM_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sym && rx_bit_cnt == 4'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_sym) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_cyc     <= '0;
      rx_bit_cnt <= 4'd0;
      rx_data    <= 8'h00;
      rx_push    <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cyc     <= '0;
          rx_bit_cnt <= 4'd0;
        end
        RX_START: rx_cyc <= rx_half ? '0 : rx_cyc + 1'b1;
        RX_DATA: begin
          if (rx_sym) begin
            rx_cyc     <= '0;
            rx_data    <= {rx_sync2, rx_data[7:1]};
            rx_bit_cnt <= rx_bit_cnt + 4'd1;
          end else begin
            rx_cyc <= rx_cyc + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_sym) begin
            rx_cyc  <= '0;
            // A low stop bit is a framing error: the byte is simply not pushed.
            rx_push <= rx_sync2;
          end else begin
            rx_cyc <= rx_cyc + 1'b1;
          end
        end
        default: rx_cyc <= '0;
      endcase
    end
  end

  // ------------------------------------------------------------- receive buffer
  logic rx_pop;
  logic rx_accept;

  assign rx_pop = DataOutValid & DataOutReady;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  // When full, a simultaneous pop frees the slot the write pointer aims at.
  assign rx_accept    = rx_push & ((count != 3'd4) | rx_pop);
  assign DataOutValid = (count != 3'd0);
  assign DataOut      = fifo_mem[rd_ptr];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (rx_accept) begin
        fifo_mem[wr_ptr] <= rx_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (rx_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({rx_accept, rx_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold_data;
  logic       hold_valid;

  assign rx_accept    = rx_push & (~hold_valid | rx_pop);
  assign DataOutValid = hold_valid;
  assign DataOut      = hold_data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
    end else if (rx_accept) begin
      hold_data  <= rx_data;
      hold_valid <= 1'b1;
    end else if (rx_pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard bench for uart_core at ClockFreq=100, BaudRate=10

module tb_uart_core;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] DataIn = 8'h00;
  logic       DataInValid = 1'b0;
  logic       DataInReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady = 1'b0;
  logic       SIn;
  logic       SOut;

  logic       sin_drv  = 1'b1;
  logic       loopback = 1'b0;
  logic       mon_en   = 1'b1;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  // 8'hA5 framed as {1, A5, 0}, LSB first
  logic       tx_seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  assign SIn = loopback ? SOut : sin_drv;

  uart_core #(.ClockFreq(100), .BaudRate(10)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .SIn          (SIn),
    .SOut         (SOut)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int w = 0;
    while (!DataInReady && w < 300) begin
      tick(1);
      w++;
    end
    if (w >= 300) chk("tx_ready_timeout", DataInReady, 1);
    DataIn      = b;
    DataInValid = 1'b1;
    tick(1);
    DataInValid = 1'b0;
    DataIn      = 8'hFF;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    sin_drv = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      sin_drv = b[i];
      tick(10);
    end
    sin_drv = stop_bit;
    tick(10);
    sin_drv = 1'b1;
    tick(10);
  endtask

  task automatic wait_drain(input int limit);
    int w = 0;
    while (exp_q.size() != 0 && w < limit) begin
      tick(1);
      w++;
    end
    chk("rx_drain", exp_q.size(), 0);
  endtask

  // Monitor: pops whatever the DUT presents and compares it to the scoreboard head.
  initial begin
    forever begin
      @(negedge Clock);
      if (mon_en && !Reset && DataOutValid === 1'b1) begin
        if (exp_q.size() == 0) chk("rx_spurious", DataOutValid, 0);
        else                   chk("rx_byte", DataOut, exp_q.pop_front());
        DataOutReady = 1'b1;
      end else begin
        DataOutReady = 1'b0;
      end
    end
  end

  initial begin
    #2;
    chk("rst_sout", SOut, 1);
    chk("rst_in_ready", DataInReady, 1);
    chk("rst_out_valid", DataOutValid, 0);
    chk("rst_dataout", DataOut, 0);
    tick(3);
    Reset = 1'b0;
    tick(2);

    // TX 8'hA5: bit pattern and ready window
    DataIn      = 8'hA5;
    DataInValid = 1'b1;
    tick(1);
    DataInValid = 1'b0;
    DataIn      = 8'h00;
    chk("tx_ready_low", DataInReady, 0);
    chk("tx_start_edge", SOut, 0);
    tick(5);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d", i), SOut, tx_seq[i]);
      if (i < 9) tick(10);
    end
    tick(4);
    chk("tx_ready_last_cycle", DataInReady, 0);
    tick(1);
    chk("tx_ready_return", DataInReady, 1);
    chk("tx_idle_line", SOut, 1);

    // loopback back-to-back
    loopback = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_tx(8'h3C);
    send_tx(8'hC3);
    wait_drain(400);
    tick(20);
    loopback = 1'b0;
    tick(5);

    // false start
    sin_drv = 1'b0;
    tick(3);
    sin_drv = 1'b1;
    tick(30);
    chk("false_start_valid", DataOutValid, 0);

    // framing error then good frame
    send_serial(8'h55, 1'b0);
    tick(20);
    chk("framing_drop_valid", DataOutValid, 0);
    exp_q.push_back(8'h12);
    send_serial(8'h12, 1'b1);
    wait_drain(200);
    tick(10);

    // three frames without popping
    mon_en = 1'b0;
    tick(2);
    send_serial(8'h01, 1'b1);
    send_serial(8'h02, 1'b1);
    send_serial(8'h03, 1'b1);
    tick(10);
    chk("overrun_valid_held", DataOutValid, 1);
`ifdef UART_RX_FIFO_EN
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
`else
    exp_q.push_back(8'h01);
`endif
    mon_en = 1'b1;
    wait_drain(50);
    tick(10);
    chk("overrun_empty_after", DataOutValid, 0);

    // reset mid-frame on both directions
    loopback = 1'b1;
    send_tx(8'hF0);
    tick(45);
    Reset = 1'b1;
    #1;
    chk("midrst_sout", SOut, 1);
    chk("midrst_in_ready", DataInReady, 1);
    chk("midrst_out_valid", DataOutValid, 0);
    chk("midrst_dataout", DataOut, 0);
    tick(3);
    Reset = 1'b0;
    tick(150);
    chk("midrst_no_partial", DataOutValid, 0);
    exp_q.push_back(8'h6B);
    send_tx(8'h6B);
    wait_drain(200);
    tick(10);
    loopback = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
